// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for the ALU with its iterative multiply/divide unit.
// Pure declarations; no timing or flow control of its own.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_NOP0     = 4'b0000,
    OP_SUB      = 4'b0001,
    OP_OR       = 4'b0010,
    OP_ADD      = 4'b0011,
    OP_LUI      = 4'b0100,
    OP_SLL      = 4'b0101,
    OP_SRL      = 4'b0110,
    OP_AND      = 4'b0111,
    OP_NOR      = 4'b1000,
    OP_SLTU     = 4'b1001,
    OP_NOTANDPC = 4'b1010,
    OP_MULTU    = 4'b1011,
    OP_DIVU     = 4'b1100,
    OP_MFHI     = 4'b1101,
    OP_MFLO     = 4'b1110,
    OP_NOP1     = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == OP_MULTU) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle.
// DATA_WIDTH cycles busy, done pulse one cycle later; starts ignored while running.
module muldiv_unit
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  div_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  fin_o,
  output logic [DATA_WIDTH-1:0] res_hi_o,
  output logic [DATA_WIDTH-1:0] res_lo_o
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH) + 1;

  md_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            div_q, div_d;
  logic [W-1:0]    opnd_q, opnd_d;
  logic [2*W-1:0]  p_q, p_d, p_step;
  logic [W:0]      mul_sum, rem_sh, diff;
  logic            last, accept;

  // p_q holds {partial product, multiplier} for MULTU and {remainder, dividend/quotient} for DIVU.
  always_comb begin
    mul_sum = {1'b0, p_q[2*W-1:W]} + (p_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh  = p_q[2*W-1:W-1];
    diff    = rem_sh - {1'b0, opnd_q};
    if (div_q) begin
      p_step = diff[W] ? {rem_sh[W-1:0], p_q[W-2:0], 1'b0}
                       : {diff[W-1:0],   p_q[W-2:0], 1'b1};
    end else begin
      p_step = {mul_sum, p_q[W-1:1]};
    end
  end

  always_comb begin
    last    = (state_q == ST_RUN) && (cnt_q == CW'(W - 1));
    accept  = start_i && (state_q != ST_RUN);
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    opnd_d  = opnd_q;
    p_d     = p_q;
    case (state_q)
      ST_RUN: begin
        p_d   = p_step;
        cnt_d = cnt_q + CW'(1);
        if (last) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      state_d = ST_RUN;
      cnt_d   = '0;
      div_d   = div_i;
      opnd_d  = b_i;
      p_d     = {{W{1'b0}}, a_i};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      opnd_q  <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      opnd_q  <= opnd_d;
      p_q     <= p_d;
    end
  end

  assign busy_o   = (state_q == ST_RUN);
  assign done_o   = (state_q == ST_DONE);
  assign fin_o    = last;
  assign res_hi_o = p_step[2*W-1:W];
  assign res_lo_o = p_step[W-1:0];

endmodule

// File: rtl/alu_muldiv.sv
// Combinational ALU plus HI/LO registers fed by the iterative multiply/divide unit.
// Single-cycle ops same-cycle; MULTU/DIVU DATA_WIDTH+1 cycles to done, new starts ignored while busy.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             alu_operation_i,
  input  logic [DATA_WIDTH-1:0]  a_i,
  input  logic [DATA_WIDTH-1:0]  b_i,
  input  logic [SHAMT_WIDTH-1:0] shamt_i,
  input  logic                   start_i,
  output logic [DATA_WIDTH-1:0]  alu_data_o,
  output logic                   zero_o,
  output logic                   topc_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [DATA_WIDTH-1:0]  hi_o,
  output logic [DATA_WIDTH-1:0]  lo_o
);

  localparam int W = DATA_WIDTH;

  logic [W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [W-1:0] res_hi, res_lo;
  logic         fin;

  muldiv_unit #(.DATA_WIDTH(W)) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .start_i  (start_i && is_muldiv(alu_operation_i)),
    .div_i    (alu_operation_i == OP_DIVU),
    .a_i      (a_i),
    .b_i      (b_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .fin_o    (fin),
    .res_hi_o (res_hi),
    .res_lo_o (res_lo)
  );

  // HI/LO only move on the completing step, so MFHI/MFLO see old values mid-run.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (fin) begin
      hi_d = res_hi;
      lo_d = res_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  always_comb begin
    alu_data_o = '0;
    case (alu_op_e'(alu_operation_i))
      OP_SUB:      alu_data_o = a_i - b_i;
      OP_OR:       alu_data_o = a_i | b_i;
      OP_ADD:      alu_data_o = a_i + b_i;
      OP_LUI:      alu_data_o = {b_i[W/2-1:0], {(W/2){1'b0}}};
      OP_SLL:      alu_data_o = b_i << shamt_i;
      OP_SRL:      alu_data_o = b_i >> shamt_i;
      OP_AND:      alu_data_o = a_i & b_i;
      OP_NOR:      alu_data_o = ~(a_i | b_i);
      OP_SLTU:     alu_data_o = W'(a_i < b_i);
      OP_NOTANDPC: alu_data_o = a_i;
      OP_MFHI:     alu_data_o = hi_q;
      OP_MFLO:     alu_data_o = lo_q;
      default:     alu_data_o = '0;
    endcase
  end

  assign zero_o = (alu_data_o == '0);
  assign topc_o = (alu_operation_i == OP_NOTANDPC);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width; even, >= 8.
REQ-002 SHALL have parameter SHAMT_WIDTH, default $clog2(DATA_WIDTH), shift-amount width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port alu_operation_i  input  4  operation select.
REQ-006 SHALL have ports a_i, b_i  input  DATA_WIDTH  operands.
REQ-007 SHALL have port shamt_i  input  SHAMT_WIDTH  shift amount.
REQ-008 SHALL have port start_i  input  1  launch strobe for multi-cycle ops.
REQ-009 SHALL have port alu_data_o  output  DATA_WIDTH  result.
REQ-010 SHALL have ports zero_o, topc_o  output  1  result-is-zero; jump-register select.
REQ-011 SHALL have port busy_o  output  1  multi-cycle op in progress.
REQ-012 SHALL have port done_o  output  1  one-cycle completion pulse.
REQ-013 SHALL have ports hi_o, lo_o  output  DATA_WIDTH  HI/LO register contents.

Function
REQ-014 Single-cycle ops SHALL be combinational, same-cycle: 0001 SUB, 0010 OR, 0011 ADD, 0100 LUI, 0101 SLL, 0110 SRL, 0111 AND, 1000 NOR, 1010 NOTANDPC (pass a_i), 1001 SLTU.
REQ-015 Arithmetic SHALL wrap modulo 2^DATA_WIDTH; SLTU result SHALL be 1 if a_i<b_i unsigned, else 0.
REQ-016 LUI SHALL output {b_i[DATA_WIDTH/2-1:0], DATA_WIDTH/2 zeros}; SLL/SRL SHALL shift b_i by shamt_i, logical.
REQ-017 Multi-cycle ops SHALL be 1011 MULTU, 1100 DIVU (unsigned); 1101 MFHI, 1110 MFLO SHALL output hi_o/lo_o combinationally; 0000, 1111 and the multi-cycle codes SHALL output 0.
REQ-018 zero_o SHALL equal (alu_data_o==0); topc_o SHALL be 1 only for code 1010.
REQ-019 FSM states SHALL be IDLE, RUN, DONE.
REQ-020 A start SHALL be accepted at an edge where start_i=1, op is MULTU/DIVU, and state is IDLE or DONE; operands latch at that edge, state goes RUN, iteration counter clears.
REQ-021 RUN SHALL perform one shift-add (MULTU) or restoring-divide (DIVU) step per edge, exactly DATA_WIDTH steps, then go DONE writing HI/LO on that same edge.
REQ-022 busy_o SHALL be 1 exactly in RUN (DATA_WIDTH cycles); done_o SHALL be 1 exactly in DONE (one cycle, DATA_WIDTH+1 cycles after acceptance edge).
REQ-023 DONE SHALL go to IDLE next edge unless a new start is accepted (back-to-back allowed).
REQ-024 MULTU SHALL write {HI,LO} = full 2*DATA_WIDTH-bit product.
REQ-025 DIVU SHALL write LO=quotient, HI=remainder; b=0 SHALL give LO=all ones, HI=a, same latency.
REQ-026 start_i during RUN, or with a non-multi-cycle op, SHALL be ignored; latched operands unchanged.
REQ-027 MFHI/MFLO during RUN SHALL return pre-operation HI/LO; HI/LO change only at the completing edge.
REQ-028 Single-cycle ops SHALL remain fully usable while busy_o=1.

Reset
REQ-029 reset SHALL force state IDLE, counter 0, HI=LO=0, busy_o=0, done_o=0 at the next edge.
REQ-030 reset during RUN SHALL abandon the op; no done_o pulse, HI/LO=0.
REQ-031 reset SHALL take priority over a simultaneous start_i.

Structure
REQ-032 Operation codes and FSM state encoding SHALL live in shared package alu_pkg.
REQ-033 Iterative datapath SHALL be one sub-module, muldiv_unit (operand/partial registers, counter); alu_muldiv holds the combinational ops, HI/LO, and output mux.

Verification
REQ-034 ADD a=5,b=7 -> alu_data_o=12, zero_o=0 same cycle; SUB a=b=7 -> 0, zero_o=1.
REQ-035 MULTU a=0xFFFFFFFF,b=2 start -> busy_o 32 cycles, done_o on 33rd, HI=1, LO=0xFFFFFFFE; MFHI -> 1.
REQ-036 DIVU a=100,b=7 -> LO=14, HI=2; DIVU a=9,b=0 -> LO=0xFFFFFFFF, HI=9.
REQ-037 MULTU 3*4 started, start_i with DIVU 8/2 at cycle 5 -> ignored; HI=0, LO=12; MFLO mid-run returns old LO.
REQ-038 reset at cycle 10 of MULTU -> next cycle busy_o=0, HI=LO=0, no done_o pulse.
REQ-039 DATA_WIDTH=16: SLL b=1,shamt=15 -> 0x8000; LUI b=0x00AB -> 0xAB00; MULTU 0xFFFF*0xFFFF -> HI=0xFFFE, LO=0x0001 after 17 cycles.
